serial_addsub: RTL

//   Parametrised, bit-serial adder/subtractor. Computes A+B or A-B (two's complement), one bit per clock, LSB first.
//   A single full-adder cell and a carry flip-flop do the work; a start/busy/done handshake wraps it.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_fulladder_cell.sv | 16 +
 rtl/serial_addsub.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encoding and mode values.
package serial_addsub_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fulladder_cell.sv
// Single-bit full adder; the only arithmetic cell of the serial adder/subtractor.
module fulladder_cell (
  input  logic in_a,
  input  logic in_b,
  input  logic in_ci,
  output logic out_co,
  output logic out_s
);

  logic half_s;

  assign half_s = in_a ^ in_b;
  assign out_s  = half_s ^ in_ci;
  assign out_co = (in_a & in_b) | (in_ci & half_s);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's complement adder/subtractor, LSB first, one bit per clock.
// Subtraction is A + ~B + 1: B is inverted at load and the carry starts at 1.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_busy,
  output logic             out_done
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic             load_c;
  logic             step_c;
  logic             last_c;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fa_co;
  logic             fa_s;

  fulladder_cell u_fa (
    .in_a   (a_q[0]),
    .in_b   (b_q[0]),
    .in_ci  (carry_q),
    .out_co (fa_co),
    .out_s  (fa_s)
  );

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = in_start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && in_start) load_c = 1'b1;
    if (state_q == ST_RUN) begin
      step_c = 1'b1;
      last_c = (cnt_q == CNT_LAST);
    end
  end

  // Operand/result shift registers, carry, counter and output flags
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
    end else begin
      out_busy <= (state_d == ST_RUN);
      out_done <= last_c;
      if (load_c) begin
        a_q        <= in_a;
        b_q        <= (in_mode == MODE_SUB) ? ~in_b : in_b;
        carry_q    <= (in_mode != MODE_ADD);
        cnt_q      <= '0;
        out_result <= '0;
        out_carry  <= 1'b0;
        out_ovf    <= 1'b0;
      end else if (step_c) begin
        a_q        <= {1'b0, a_q[WIDTH-1:1]};
        b_q        <= {1'b0, b_q[WIDTH-1:1]};
        carry_q    <= fa_co;
        cnt_q      <= cnt_q + CNT_W'(1);
        out_result <= {fa_s, out_result[WIDTH-1:1]};
        // carry_q is the carry into the MSB on the last bit-cycle
        if (last_c) begin
          out_carry <= fa_co;
          out_ovf   <= carry_q ^ fa_co;
        end
      end
    end
  end

endmodule
